// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
// Shares one single-port frame-buffer RAM between the VGA read path and the
// camera write stream. Reads own the port whenever the prefetch coordinate
// (two pixels ahead of the beam) falls inside the display window. Camera
// writes wait in a small FIFO and drain in every cycle the reader leaves free.

module fb_port_arbiter #(
    parameter int WIN_X0     = 20,
    parameter int WIN_X1     = 620,
    parameter int WIN_Y0     = 40,
    parameter int WIN_Y1     = 440,
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 18,
    parameter int PIX_W      = 4
) (
    input  logic              pixel_clk,
    input  logic              rst_n,
    input  logic [9:0]        hcnt,
    input  logic [9:0]        vcnt,
    output logic [PIX_W-1:0]  pix_out,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              ovf,
    input  logic              clr_ovf
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [10:0]        X0_C         = 11'(WIN_X0);
    localparam logic [10:0]        X1_C         = 11'(WIN_X1);
    localparam logic [10:0]        Y0_C         = 11'(WIN_Y0);
    localparam logic [10:0]        Y1_C         = 11'(WIN_Y1);
    localparam logic [10:0]        H_TOT_C      = 11'(H_TOTAL);
    localparam logic [10:0]        V_TOT_C      = 11'(V_TOTAL);
    localparam logic [CNT_W-1:0]   FULL_C       = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_ZERO_C   = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE_C    = CNT_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE_C    = PTR_W'(1);
    localparam logic [ADDR_W-1:0]  ADDR_LIMIT_C = ADDR_W'((WIN_X1 - WIN_X0) * (WIN_Y1 - WIN_Y0));

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2
    } arb_e;

    // Prefetch coordinate and window decode
    logic [10:0]       lx_raw_s;
    logic              hwrap_s;
    logic [10:0]       lx_s;
    logic [10:0]       ly_raw_s;
    logic [10:0]       ly_s;
    logic              rd_win_s;
    logic [10:0]       row_s;
    logic [10:0]       col_s;
    logic [ADDR_W-1:0] row_ext_s;
    logic [ADDR_W-1:0] col_ext_s;
    logic [ADDR_W-1:0] rd_addr_s;

    // FIFO state
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [PIX_W-1:0]  fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wp_q;
    logic [PTR_W-1:0]  rp_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              wr_ready_q;
    logic              fifo_empty_s;
    logic              addr_bad_s;
    logic              push_s;
    logic              pop_s;

    // Port and status registers
    arb_e              arb_s;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [PIX_W-1:0]  mem_wdata_q;
    logic              ovf_q;
    logic              ovf_d;
    logic              rd_v1_q;
    logic              rd_v2_q;

    // Look two pixels ahead; wrap into the next line and the next frame.
    assign lx_raw_s = {1'b0, hcnt} + 11'd2;
    assign hwrap_s  = (lx_raw_s >= H_TOT_C);
    assign lx_s     = hwrap_s ? (lx_raw_s - H_TOT_C) : lx_raw_s;
    assign ly_raw_s = {1'b0, vcnt} + {10'd0, hwrap_s};
    assign ly_s     = (ly_raw_s >= V_TOT_C) ? 11'd0 : ly_raw_s;

    assign rd_win_s = (lx_s >= X0_C) && (lx_s < X1_C) && (ly_s >= Y0_C) && (ly_s < Y1_C);

    // Row-major linear address; row * 600 built from shifts (512+64+16+8).
    assign row_s     = ly_s - Y0_C;
    assign col_s     = lx_s - X0_C;
    assign row_ext_s = ADDR_W'(row_s);
    assign col_ext_s = ADDR_W'(col_s);
    assign rd_addr_s = (row_ext_s << 4'd9) + (row_ext_s << 4'd6) + (row_ext_s << 4'd4)
                     + (row_ext_s << 4'd3) + col_ext_s;

    // Out-of-range writes complete the handshake but never enter the FIFO.
    assign fifo_empty_s = (count_q == CNT_ZERO_C);
    assign addr_bad_s   = (wr_addr >= ADDR_LIMIT_C);
    assign push_s       = wr_valid & wr_ready_q & ~addr_bad_s;
    assign pop_s        = (arb_s == ARB_WR);

    // Per-cycle port owner: reads always win, writes use any leftover cycle.
    always_comb begin
        arb_s = ARB_IDLE;
        if (rd_win_s) begin
            arb_s = ARB_RD;
        end else if (!fifo_empty_s) begin
            arb_s = ARB_WR;
        end else begin
            arb_s = ARB_IDLE;
        end
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Sticky error flag: a set event in the same cycle beats the clear.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_valid && (!wr_ready_q || addr_bad_s)) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // FIFO storage array; contents need no reset, pointers guard validity.
    always_ff @(posedge pixel_clk) begin
        if (push_s) begin
            fifo_addr_q[wp_q] <= wr_addr;
            fifo_data_q[wp_q] <= wr_data;
        end
    end

    // Arbiter state: FIFO pointers, RAM port registers, read-valid pipeline.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q        <= {PTR_W{1'b0}};
            rp_q        <= {PTR_W{1'b0}};
            count_q     <= CNT_ZERO_C;
            wr_ready_q  <= 1'b1;
            ovf_q       <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_we_q    <= 1'b0;
            mem_wdata_q <= {PIX_W{1'b0}};
            rd_v1_q     <= 1'b0;
            rd_v2_q     <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ready_q <= (count_d != FULL_C);
            ovf_q      <= ovf_d;
            rd_v1_q    <= rd_win_s;
            rd_v2_q    <= rd_v1_q;
            if (push_s) begin
                wp_q <= wp_q + PTR_ONE_C;
            end
            if (pop_s) begin
                rp_q <= rp_q + PTR_ONE_C;
            end
            case (arb_s)
                ARB_RD: begin
                    mem_addr_q <= rd_addr_s;
                    mem_we_q   <= 1'b0;
                end
                ARB_WR: begin
                    mem_addr_q  <= fifo_addr_q[rp_q];
                    mem_wdata_q <= fifo_data_q[rp_q];
                    mem_we_q    <= 1'b1;
                end
                default: begin
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready  = wr_ready_q;
    assign ovf       = ovf_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    // RAM data lines up with the beam two cycles after the prefetch decision.
    assign pix_out   = rd_v2_q ? mem_rdata : {PIX_W{1'b0}};

endmodule
